pipeline_ctrl: RTL and testbench

Hazard and sequencing controller for the five-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC. It issues per-register enable and flush (bubble-insert) signals that resolve load-use hazards, taken-branch squashes, multi-cycle memory waits and post-reset pipeline fill. It sits beside the hazard-free datapath; each pipeline register captures on posedge `Clk` when its enable is high, loading zero instead of its input when its flush is high.

---
 rtl/pipeline_ctrl.sv | 126 ++++++++++++
 tb/tb_pipeline_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller for the five-stage pipeline: drives per-register
// enables and bubble-insert flushes for fill, load-use, branch squash and memory waits.
module pipeline_ctrl #(
  parameter int FILL_CYCLES  = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int COUNT_W      = 16
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [4:0]         IFID_Rs,
  input  logic [4:0]         IFID_Rt,
  input  logic               IFID_UsesRt,
  input  logic               IDEX_MemRead,
  input  logic [4:0]         IDEX_Rt,
  input  logic               EX_BranchTaken,
  input  logic               MemReq,
  input  logic               MemReady,
  output logic               PCWrite,
  output logic               IFID_En,
  output logic               IDEX_En,
  output logic               EXMEM_En,
  output logic               MEMWB_En,
  output logic               IFID_Flush,
  output logic               IDEX_Flush,
  output logic [COUNT_W-1:0] StallCount,
  output logic [1:0]         State
);

  typedef enum logic [1:0] {
    ST_FILL    = 2'd0,
    ST_RUN     = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_MEMWAIT = 2'd3
  } state_t;

  localparam logic [3:0] FILL_INIT  = 4'(FILL_CYCLES);
  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

  state_t             state_reg, state_next;
  logic [3:0]         cnt_reg, cnt_next;
  logic [COUNT_W-1:0] stall_reg;

  // en bits: {PCWrite, IFID_En, IDEX_En, EXMEM_En, MEMWB_En}; fl bits: {IFID, IDEX}
  logic [4:0] en;
  logic [1:0] fl;
  logic       freeze;
  logic       load_use;

  assign freeze   = MemReq & ~MemReady;
  assign load_use = IDEX_MemRead && (IDEX_Rt != 5'd0) &&
                    ((IDEX_Rt == IFID_Rs) || (IFID_UsesRt && (IDEX_Rt == IFID_Rt)));

  always_comb begin
    en         = 5'b11111;
    fl         = 2'b00;
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (Reset) begin
      en = 5'b00000;
      fl = 2'b11;
    end else begin
      case (state_reg)
        ST_FILL: begin
          fl       = 2'b11;
          cnt_next = cnt_reg - 4'd1;
          if (cnt_reg == 4'd1) state_next = ST_RUN;
        end
        ST_FLUSH: begin
          if (freeze) begin
            en = 5'b00000;
          end else begin
            fl       = 2'b11;
            cnt_next = cnt_reg - 4'd1;
            if (cnt_reg == 4'd1) state_next = ST_RUN;
          end
        end
        ST_RUN, ST_MEMWAIT: begin
          // RUN and an unfrozen MEMWAIT share the same rule ladder
          if (freeze) begin
            en         = 5'b00000;
            state_next = ST_MEMWAIT;
          end else if (EX_BranchTaken) begin
            fl = 2'b11;
            if (FLUSH_CYCLES > 1) begin
              state_next = ST_FLUSH;
              cnt_next   = FLUSH_INIT;
            end else begin
              state_next = ST_RUN;
            end
          end else if (load_use) begin
            en         = 5'b00111;
            fl         = 2'b01;
            state_next = ST_RUN;
          end else begin
            state_next = ST_RUN;
          end
        end
        default: state_next = ST_FILL;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg <= ST_FILL;
      cnt_reg   <= FILL_INIT;
      stall_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if ((state_reg != ST_FILL) && !en[4] && (stall_reg != {COUNT_W{1'b1}}))
        stall_reg <= stall_reg + 1'b1;
    end
  end

  assign PCWrite    = en[4];
  assign IFID_En    = en[3];
  assign IDEX_En    = en[2];
  assign EXMEM_En   = en[1];
  assign MEMWB_En   = en[0];
  assign IFID_Flush = fl[1];
  assign IDEX_Flush = fl[0];
  assign StallCount = stall_reg;
  assign State      = state_reg;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed vectors push hand-computed
// expectations; a negedge monitor pops and compares each cycle's outputs.
module tb_pipeline_ctrl;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [4:0] IFID_Rs, IFID_Rt, IDEX_Rt;
  logic       IFID_UsesRt, IDEX_MemRead, EX_BranchTaken, MemReq, MemReady;
  logic       PCWrite, IFID_En, IDEX_En, EXMEM_En, MEMWB_En, IFID_Flush, IDEX_Flush;
  logic [3:0] StallCount;
  logic [1:0] State;

  pipeline_ctrl #(.FILL_CYCLES(2), .FLUSH_CYCLES(3), .COUNT_W(4)) dut (
    .Clk(Clk), .Reset(Reset),
    .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt), .IFID_UsesRt(IFID_UsesRt),
    .IDEX_MemRead(IDEX_MemRead), .IDEX_Rt(IDEX_Rt),
    .EX_BranchTaken(EX_BranchTaken), .MemReq(MemReq), .MemReady(MemReady),
    .PCWrite(PCWrite), .IFID_En(IFID_En), .IDEX_En(IDEX_En),
    .EXMEM_En(EXMEM_En), .MEMWB_En(MEMWB_En),
    .IFID_Flush(IFID_Flush), .IDEX_Flush(IDEX_Flush),
    .StallCount(StallCount), .State(State)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string      name;
    logic [1:0] st;
    logic [4:0] en;
    logic [1:0] fl;
    logic [3:0] sc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   stim_done = 1'b0;

  // Drive one cycle of inputs and queue the outputs expected during that cycle
  task automatic vec(input string name, input logic rst, input logic br,
                     input logic mreq, input logic mrdy, input logic memrd,
                     input logic [4:0] idexrt, input logic [4:0] rs,
                     input logic [4:0] rt, input logic usesrt,
                     input logic [1:0] st, input logic [4:0] en,
                     input logic [1:0] fl, input logic [3:0] sc);
    exp_t e;
    @(posedge Clk);
    #1;
    Reset = rst; EX_BranchTaken = br; MemReq = mreq; MemReady = mrdy;
    IDEX_MemRead = memrd; IDEX_Rt = idexrt; IFID_Rs = rs; IFID_Rt = rt;
    IFID_UsesRt = usesrt;
    e.name = name; e.st = st; e.en = en; e.fl = fl; e.sc = sc;
    exp_q.push_back(e);
  endtask

  always @(negedge Clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [12:0] got, want;
      e    = exp_q.pop_front();
      got  = {State, PCWrite, IFID_En, IDEX_En, EXMEM_En, MEMWB_En,
              IFID_Flush, IDEX_Flush, StallCount};
      want = {e.st, e.en, e.fl, e.sc};
      n_checks++;
      if (got === want) begin
        n_pass++;
        $display("ok   %s: st=%0d en=%b fl=%b sc=%0d", e.name, State,
                 got[10:6], got[5:4], StallCount);
      end else begin
        $display("FAIL %s: got st=%0d en=%b fl=%b sc=%0d, want st=%0d en=%b fl=%b sc=%0d",
                 e.name, State, got[10:6], got[5:4], StallCount,
                 e.st, e.en, e.fl, e.sc);
      end
    end
  end

  localparam logic [4:0] EA = 5'b11111;
  localparam logic [4:0] EL = 5'b00111;
  localparam logic [4:0] EZ = 5'b00000;

  initial begin
    Reset = 1'b1; EX_BranchTaken = 0; MemReq = 0; MemReady = 0;
    IDEX_MemRead = 0; IDEX_Rt = 0; IFID_Rs = 0; IFID_Rt = 0; IFID_UsesRt = 0;
    repeat (2) @(posedge Clk);

    //   name            rst br rq rd mr xrt rs rt ur   st en  fl sc
    vec("reset",          1, 1, 1, 0, 1, 5, 5, 0, 0,   0, EZ, 3, 0);
    vec("fill1_ignore",   0, 1, 1, 0, 1, 5, 5, 0, 0,   0, EA, 3, 0);
    vec("fill2",          0, 0, 0, 0, 0, 0, 0, 0, 0,   0, EA, 3, 0);
    vec("run_idle",       0, 0, 0, 0, 0, 0, 0, 0, 0,   1, EA, 0, 0);
    vec("lu_rs",          0, 0, 0, 0, 1, 5, 5, 0, 0,   1, EL, 1, 0);
    vec("lu_cleared",     0, 0, 0, 0, 0, 0, 0, 0, 0,   1, EA, 0, 1);
    vec("lu_rt",          0, 0, 0, 0, 1, 7, 3, 7, 1,   1, EL, 1, 1);
    vec("rt_not_used",    0, 0, 0, 0, 1, 7, 3, 7, 0,   1, EA, 0, 2);
    vec("rt_zero",        0, 0, 0, 0, 1, 0, 0, 0, 0,   1, EA, 0, 2);
    vec("branch_and_lu",  0, 1, 0, 0, 1, 5, 5, 0, 0,   1, EA, 3, 2);
    vec("flush_br_ign",   0, 1, 0, 0, 0, 0, 0, 0, 0,   2, EA, 3, 2);
    vec("flush_frz1",     0, 0, 1, 0, 0, 0, 0, 0, 0,   2, EZ, 0, 2);
    vec("flush_frz2",     0, 0, 1, 0, 0, 0, 0, 0, 0,   2, EZ, 0, 3);
    vec("flush_release",  0, 0, 1, 1, 0, 0, 0, 0, 0,   2, EA, 3, 4);
    vec("run_after_fl",   0, 0, 0, 0, 0, 0, 0, 0, 0,   1, EA, 0, 4);
    vec("run_freeze",     0, 0, 1, 0, 0, 0, 0, 0, 0,   1, EZ, 0, 4);
    vec("mw_freeze1",     0, 0, 1, 0, 0, 0, 0, 0, 0,   3, EZ, 0, 5);
    vec("mw_freeze2",     0, 0, 1, 0, 0, 0, 0, 0, 0,   3, EZ, 0, 6);
    vec("mw_ready",       0, 0, 1, 1, 0, 0, 0, 0, 0,   3, EA, 0, 7);
    vec("run_after_mw",   0, 0, 0, 0, 0, 0, 0, 0, 0,   1, EA, 0, 7);
    vec("run_freeze2",    0, 0, 1, 0, 0, 0, 0, 0, 0,   1, EZ, 0, 7);
    vec("mw_ready_lu",    0, 0, 1, 1, 1, 5, 5, 0, 0,   3, EL, 1, 8);
    vec("run_after_mwlu", 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, EA, 0, 9);
    vec("run_freeze3",    0, 0, 1, 0, 0, 0, 0, 0, 0,   1, EZ, 0, 9);
    vec("mw_ready_br",    0, 1, 1, 1, 0, 0, 0, 0, 0,   3, EA, 3, 10);
    vec("mw_br_flush1",   0, 0, 0, 0, 0, 0, 0, 0, 0,   2, EA, 3, 10);
    vec("mw_br_flush2",   0, 0, 0, 0, 0, 0, 0, 0, 0,   2, EA, 3, 10);
    vec("run_pre_sat",    0, 0, 0, 0, 0, 0, 0, 0, 0,   1, EA, 0, 10);
    for (int i = 0; i < 8; i++) begin
      logic [3:0] sc_exp;
      sc_exp = (10 + i > 15) ? 4'd15 : 4'(10 + i);
      vec($sformatf("lu_sat_%0d", i), 0, 0, 0, 0, 1, 9, 9, 0, 0, 1, EL, 1, sc_exp);
    end
    vec("sat_hold",       0, 0, 0, 0, 0, 0, 0, 0, 0,   1, EA, 0, 15);
    vec("sat_freeze",     0, 0, 1, 0, 0, 0, 0, 0, 0,   1, EZ, 0, 15);
    vec("sat_mw_frz",     0, 0, 1, 0, 0, 0, 0, 0, 0,   3, EZ, 0, 15);
    vec("reset_in_mw",    1, 0, 1, 0, 0, 0, 0, 0, 0,   3, EZ, 3, 15);
    vec("refill1",        0, 0, 0, 0, 0, 0, 0, 0, 0,   0, EA, 3, 0);
    vec("refill2",        0, 0, 0, 0, 0, 0, 0, 0, 0,   0, EA, 3, 0);
    vec("run_branch",     0, 1, 0, 0, 0, 0, 0, 0, 0,   1, EA, 3, 0);
    vec("flush_again",    0, 0, 0, 0, 0, 0, 0, 0, 0,   2, EA, 3, 0);
    vec("reset_in_flush", 1, 0, 0, 0, 0, 0, 0, 0, 0,   2, EZ, 3, 0);
    vec("refill3",        0, 0, 0, 0, 0, 0, 0, 0, 0,   0, EA, 3, 0);
    vec("refill4",        0, 0, 0, 0, 0, 0, 0, 0, 0,   0, EA, 3, 0);
    vec("run_final",      0, 0, 0, 0, 0, 0, 0, 0, 0,   1, EA, 0, 0);

    begin
      int waited = 0;
      while (exp_q.size() > 0 && waited < 10) begin
        @(posedge Clk);
        waited++;
      end
      @(posedge Clk);
      if (exp_q.size() > 0) begin
        n_checks++;
        $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
      end
    end
    stim_done = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    if (!stim_done) begin
      $display("FAIL timeout: got no completion by 100000, want completion");
      $fatal(1, "timeout");
    end
  end

endmodule
